branch_cond_unit: RTL
=====================

# branch_cond_unit

- Sequential consumer of the ALU status flags (S, Z, C, V).
- Latches the flags into an architectural flag register, accepts branch requests over a valid/ready handshake and evaluates the branch condition.
- Stalls while a flag-producing instruction is still in flight.
- Returns a taken/not-taken decision and the next PC to the fetch stage.

## Interface
Parameters:
- W, 16, data/PC width; all PC arithmetic is modulo 2^W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flag_we  in  1  ALU writeback strobe; the flag register is loaded from alu_s/z/c/v this cycle.
- alu_s, alu_z, alu_c, alu_v  in  1 each  ALU status flags.
- flag_pend  in  1  a flag-writing instruction has issued but has not yet written back.
- br_valid  in  1  branch request valid.
- br_ready  out  1  unit can accept a request.
- br_cond  in  4  condition code.
- br_pc  in  W  PC of the branch instruction.
- br_disp  in  W  signed displacement.
- res_valid  out  1  one-cycle result strobe.
- res_taken  out  1  branch taken; meaningful only while res_valid is high.
- res_illegal  out  1  reserved condition code was used; meaningful only while res_valid is high.
- res_target  out  W  next PC; meaningful only while res_valid is high.
- flags  out  4  flag register, ordered {S,Z,C,V}.

## Operation
Flag register:
- Loads when flag_we=1, in any FSM state.
- Otherwise holds its value.

Condition codes (L = S^V):
- 0 BE: Z
- 1 BNE: !Z
- 2 BLT: L
- 3 BLE: Z|L
- 4 BGE: !L
- 5 BGT: !Z&!L
- 6 BCS: C
- 7 BCC: !C
- 8 BMI: S
- 9 BPL: !S
- 10 BVS: V
- 11 BVC: !V
- 12, 13: reserved. Result is not taken with res_illegal=1.
- 14 ALWAYS: taken.
- 15 NEVER: not taken.

FSM states: IDLE, CHECK, DONE.
- IDLE
  - br_ready=1.
  - On br_valid=1, capture cond, pc and disp, then go to CHECK.
- CHECK
  - br_ready=0.
  - Codes 12–15 do not depend on flags: evaluate this cycle.
  - Other codes with flag_pend=1 or flag_we=1: stay in CHECK.
  - Other codes otherwise: evaluate from the flag register.
  - After evaluating, register taken/illegal/target and go to DONE.
- DONE
  - res_valid=1 for exactly this one cycle.
  - br_ready=0.
  - Next state is IDLE.

Target computation:
- taken: br_pc + 1 + br_disp.
- not taken (including illegal): br_pc + 1.
- Both sums are truncated to W bits; wrap-around is silent.

Reset:
- Next state IDLE.
- flags=0, res_valid=0, res_taken=0, res_illegal=0, res_target=0.
- br_ready=1 from the cycle after reset deasserts.
- A captured but unresolved request is discarded; no res_valid is ever produced for it.

Outputs:
- res_taken, res_illegal and res_target hold their last values outside DONE.

## Timing
Latency, with the request accepted at edge t:
- No stall: CHECK during t..t+1, res_valid high during cycle t+2.
- Stall: when flag_we is sampled high in CHECK at edge u, evaluation happens in the following cycle and res_valid is high during cycle u+2.
- Throughput: at most one branch per 3 cycles. br_valid is not sampled outside IDLE.

Flag writeback rules:
- flag_we is never forwarded. A request accepted in the same cycle as flag_we waits one CHECK cycle and evaluates against the newly written flags.
- If flag_we and flag_pend are both high, the unit keeps stalling until flag_pend falls.

## Structure
Package branch_cond_pkg contains:
- cond_e: the 4-bit enum of the codes above.
- state_e: {IDLE, CHECK, DONE}.
- flags_t: packed struct {s,z,c,v}.

Sub-module cond_eval:
- Purely combinational.
- Inputs: cond_e, flags_t.
- Outputs: taken, illegal.
- The top level holds the FSM, the flag register, the captured request and the target adder.

## Test plan
- Reset held 2 cycles → flags=0000, br_ready=1, res_valid=0, res_target=0x0000. Assert reset while in CHECK → no res_valid, and the unit is in IDLE the cycle after reset deasserts.
- Flag load then BLT: flag_we with S=1, V=0; then BLT with pc=0x0010, disp=0x0005 → res_valid at t+2, taken=1, target=0x0016.
- BLE not taken: flags S=1, V=1, Z=0; BLE with pc=0x0010 → taken=0, target=0x0011.
- Stall on pending flags: BE accepted; flag_pend=1 for 3 cycles, then flag_we with Z=1 and flag_pend=0 at edge u → res_valid at u+2, taken=1. No res_valid during the stall.
- Target wrap-around:
  - ALWAYS with pc=0xFFFE, disp=0x0003 → target=0x0002.
  - ALWAYS with disp=0xFFFF → target=pc.
  - NEVER while flag_pend=1 → resolves without stalling, target=pc+1.
- Reserved code and handshake: cond=12 → res_illegal=1, taken=0. br_valid held high continuously → exactly one acceptance per 3 cycles.

Source files
------------

// File: rtl/branch_cond_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_cond_pkg: shared types for the branch condition unit      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package branch_cond_pkg;

    typedef enum logic [3:0] {
        COND_BE     = 4'd0,
        COND_BNE    = 4'd1,
        COND_BLT    = 4'd2,
        COND_BLE    = 4'd3,
        COND_BGE    = 4'd4,
        COND_BGT    = 4'd5,
        COND_BCS    = 4'd6,
        COND_BCC    = 4'd7,
        COND_BMI    = 4'd8,
        COND_BPL    = 4'd9,
        COND_BVS    = 4'd10,
        COND_BVC    = 4'd11,
        COND_RSV12  = 4'd12,
        COND_RSV13  = 4'd13,
        COND_ALWAYS = 4'd14,
        COND_NEVER  = 4'd15
    } cond_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic s;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Codes 12..15 resolve without looking at the flag register, so they never stall.
    function automatic logic cond_uses_flags(input cond_e c);
        return !(c inside {COND_RSV12, COND_RSV13, COND_ALWAYS, COND_NEVER});
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cond_unit_cond_eval.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cond_eval: combinational branch condition decoder                |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module cond_eval
    import branch_cond_pkg::*;
(
    input  cond_e  cond,
    input  flags_t flags,
    output logic   taken,
    output logic   illegal
);

    logic w_less;

    // Signed less-than after a compare: sign differs from overflow.
    assign w_less = flags.s ^ flags.v;

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (cond)
            COND_BE:     taken = flags.z;
            COND_BNE:    taken = !flags.z;
            COND_BLT:    taken = w_less;
            COND_BLE:    taken = flags.z | w_less;
            COND_BGE:    taken = !w_less;
            COND_BGT:    taken = !flags.z & !w_less;
            COND_BCS:    taken = flags.c;
            COND_BCC:    taken = !flags.c;
            COND_BMI:    taken = flags.s;
            COND_BPL:    taken = !flags.s;
            COND_BVS:    taken = flags.v;
            COND_BVC:    taken = !flags.v;
            COND_RSV12,
            COND_RSV13:  illegal = 1'b1;
            COND_ALWAYS: taken = 1'b1;
            COND_NEVER:  taken = 1'b0;
            default:     taken = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_cond_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | branch_cond_unit: flag register, branch handshake and resolution |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module branch_cond_unit
    import branch_cond_pkg::*;
#(
    parameter int W = 16
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         flag_we,
    input  logic         alu_s,
    input  logic         alu_z,
    input  logic         alu_c,
    input  logic         alu_v,
    input  logic         flag_pend,
    input  logic         br_valid,
    output logic         br_ready,
    input  logic [3:0]   br_cond,
    input  logic [W-1:0] br_pc,
    input  logic [W-1:0] br_disp,
    output logic         res_valid,
    output logic         res_taken,
    output logic         res_illegal,
    output logic [W-1:0] res_target,
    output logic [3:0]   flags
);

    localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};

    state_e       r_state;
    flags_t       r_flags;
    cond_e        r_cond;
    logic [W-1:0] r_pc;
    logic [W-1:0] r_disp;
    logic         r_taken;
    logic         r_illegal;
    logic [W-1:0] r_target;

    logic         w_taken;
    logic         w_illegal;
    logic         w_flag_dep;
    logic         w_eval;
    logic [W-1:0] w_pc_inc;
    logic [W-1:0] w_target;

    cond_eval u_cond_eval (
        .cond    (r_cond),
        .flags   (r_flags),
        .taken   (w_taken),
        .illegal (w_illegal)
    );

    // A writeback in flight or landing this cycle is not forwarded; wait for the register.
    assign w_flag_dep = cond_uses_flags(r_cond);
    assign w_eval     = (r_state == CHECK) && (!w_flag_dep || (!flag_pend && !flag_we));

    assign w_pc_inc   = r_pc + C_ONE;
    assign w_target   = w_taken ? (w_pc_inc + r_disp) : w_pc_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else if (flag_we) begin
            r_flags <= {alu_s, alu_z, alu_c, alu_v};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (br_valid) r_state <= CHECK;
                CHECK:   if (w_eval)   r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cond <= COND_BE;
            r_pc   <= '0;
            r_disp <= '0;
        end else if (r_state == IDLE && br_valid) begin
            r_cond <= cond_e'(br_cond);
            r_pc   <= br_pc;
            r_disp <= br_disp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_taken   <= 1'b0;
            r_illegal <= 1'b0;
            r_target  <= '0;
        end else if (w_eval) begin
            r_taken   <= w_taken;
            r_illegal <= w_illegal;
            r_target  <= w_target;
        end
    end

    assign br_ready    = (r_state == IDLE);
    assign res_valid   = (r_state == DONE);
    assign res_taken   = r_taken;
    assign res_illegal = r_illegal;
    assign res_target  = r_target;
    assign flags       = r_flags;

endmodule
`default_nettype wire
